// File: rtl/pulse_burst_pkg.sv
// Shared types and default widths for the pulse burst generator.
package pulse_burst_pkg;

    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned N_W_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; saturates at zero.
module pulse_phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign expired = (r_cnt == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Generates a burst of N pulses with programmable high/low phase lengths.
module pulse_burst_gen
    import pulse_burst_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned N_W   = N_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_W-1:0]   num_pulses,
    input  logic [CNT_W-1:0] high_cyc,
    input  logic [CNT_W-1:0] low_cyc,
    output logic             sig_out,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [N_W-1:0]   r_pulses;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_low;
    logic             r_sig_out;
    logic             r_done;

    state_t           w_next_state;
    logic [N_W-1:0]   w_pulses_nxt;
    logic [CNT_W-1:0] w_high_nxt;
    logic [CNT_W-1:0] w_low_nxt;
    logic             w_done_nxt;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_expired;

    // Phase length minus one, with a zero length treated as one cycle.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    pulse_phase_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pulses  <= '0;
            r_high    <= '0;
            r_low     <= '0;
            r_sig_out <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pulses  <= w_pulses_nxt;
            r_high    <= w_high_nxt;
            r_low     <= w_low_nxt;
            r_sig_out <= (w_next_state == HIGH);
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pulses_nxt = r_pulses;
        w_high_nxt   = r_high;
        w_low_nxt    = r_low;
        w_done_nxt   = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_pulses_nxt = num_pulses;
                    w_high_nxt   = high_cyc;
                    w_low_nxt    = low_cyc;
                    if (num_pulses == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_next_state = HIGH;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = len_m1(high_cyc);
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    w_next_state = IDLE;
                    w_pulses_nxt = '0;
                end else if (w_expired) begin
                    w_next_state = LOW;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = len_m1(r_low);
                end
            end
            LOW: begin
                if (abort) begin
                    w_next_state = IDLE;
                    w_pulses_nxt = '0;
                end else if (w_expired) begin
                    w_pulses_nxt = r_pulses - N_W'(1);
                    if (r_pulses == N_W'(1)) begin
                        w_next_state = IDLE;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_next_state = HIGH;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = len_m1(r_high);
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign sig_out = r_sig_out;
    assign done    = r_done;
    assign ready   = (r_state == IDLE);
    assign busy    = (r_state == HIGH) || (r_state == LOW);

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen: vector table plus abort/back-to-back/reset sequences.
module tb_pulse_burst_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] num_pulses;
    logic [3:0] high_cyc;
    logic [3:0] low_cyc;
    logic       sig_out;
    logic       ready;
    logic       busy;
    logic       done;

    int n_total;
    int n_bad;

    typedef struct {
        logic [2:0] n;
        logic [3:0] h;
        logic [3:0] l;
        string      pat;
        int         done_at;
    } vec_t;

    vec_t vecs[7];

    pulse_burst_gen #(
        .CNT_W (4),
        .N_W   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_pulses (num_pulses),
        .high_cyc   (high_cyc),
        .low_cyc    (low_cyc),
        .sig_out    (sig_out),
        .ready      (ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic e_sig, input logic e_busy,
                            input logic e_done);
        chk({nm, " sig_out"}, sig_out, e_sig);
        chk({nm, " busy"}, busy, e_busy);
        chk({nm, " ready"}, ready, !e_busy);
        chk({nm, " done"}, done, e_done);
    endtask

    // Start at cycle T, scramble inputs afterwards, check every cycle through done.
    task automatic run_burst(input vec_t v, input string tag);
        logic e_sig;
        start      = 1'b1;
        num_pulses = v.n;
        high_cyc   = v.h;
        low_cyc    = v.l;
        tick();
        start      = 1'b0;
        num_pulses = 3'($urandom);
        high_cyc   = 4'($urandom);
        low_cyc    = 4'($urandom);
        for (int k = 1; k <= v.done_at; k++) begin
            e_sig = (k <= v.pat.len()) ? (v.pat[k-1] == "1") : 1'b0;
            chk_outs($sformatf("%s T+%0d", tag, k), e_sig, k < v.done_at, k == v.done_at);
            if (k < v.done_at) tick();
        end
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        num_pulses = '0;
        high_cyc   = '0;
        low_cyc    = '0;

        vecs[0] = '{n: 3'd3, h: 4'd1,  l: 4'd1, pat: "101010",                done_at: 7};
        vecs[1] = '{n: 3'd2, h: 4'd3,  l: 4'd2, pat: "1110011100",            done_at: 11};
        vecs[2] = '{n: 3'd0, h: 4'd5,  l: 4'd5, pat: "",                      done_at: 1};
        vecs[3] = '{n: 3'd2, h: 4'd0,  l: 4'd0, pat: "1010",                  done_at: 5};
        vecs[4] = '{n: 3'd1, h: 4'd2,  l: 4'd3, pat: "11000",                 done_at: 6};
        vecs[5] = '{n: 3'd7, h: 4'd1,  l: 4'd2, pat: "100100100100100100100", done_at: 22};
        vecs[6] = '{n: 3'd1, h: 4'd15, l: 4'd1, pat: "1111111111111110",      done_at: 17};

        #2;
        chk_outs("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_outs("idle after reset", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i], $sformatf("vec%0d", i));
            tick();
            chk_outs($sformatf("vec%0d after done", i), 1'b0, 1'b0, 1'b0);
        end

        // Abort during LOW of N=4,H=2,L=2: pattern 1100..., abort seen at T+4.
        start = 1'b1; num_pulses = 3'd4; high_cyc = 4'd2; low_cyc = 4'd2;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk_outs("abort T+4", 1'b0, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_outs("abort T+5", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk_outs($sformatf("post-abort +%0d", k), 1'b0, 1'b0, 1'b0);
        end

        // abort and start together in IDLE: start ignored.
        start = 1'b1; abort = 1'b1; num_pulses = 3'd2; high_cyc = 4'd1; low_cyc = 4'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_outs("abort+start idle", 1'b0, 1'b0, 1'b0);
        tick();
        chk_outs("abort+start idle +2", 1'b0, 1'b0, 1'b0);

        // Back-to-back: second start in the done cycle, then start while busy ignored.
        start = 1'b1; num_pulses = 3'd1; high_cyc = 4'd1; low_cyc = 4'd1;
        tick();
        start = 1'b0;
        chk_outs("b2b T+1", 1'b1, 1'b1, 1'b0);
        tick();
        chk_outs("b2b T+2", 1'b0, 1'b1, 1'b0);
        tick();
        chk_outs("b2b T+3 done", 1'b0, 1'b0, 1'b1);
        start = 1'b1; num_pulses = 3'd2; high_cyc = 4'd1; low_cyc = 4'd1;
        tick();
        chk_outs("b2b T+4 second high", 1'b1, 1'b1, 1'b0);
        num_pulses = 3'd7; high_cyc = 4'd3; low_cyc = 4'd3;
        tick();
        start = 1'b0;
        chk_outs("b2b T+5", 1'b0, 1'b1, 1'b0);
        tick();
        chk_outs("b2b T+6", 1'b1, 1'b1, 1'b0);
        tick();
        chk_outs("b2b T+7", 1'b0, 1'b1, 1'b0);
        tick();
        chk_outs("b2b T+8 done", 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("b2b T+9 idle", 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-HIGH drops sig_out without a clock edge.
        start = 1'b1; num_pulses = 3'd3; high_cyc = 4'd4; low_cyc = 4'd1;
        tick();
        start = 1'b0;
        tick();
        chk_outs("pre-reset high", 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async reset", 1'b0, 1'b0, 1'b0);
        tick();
        chk_outs("in reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_outs($sformatf("post-reset +%0d", k), 1'b0, 1'b0, 1'b0);
        end
        run_burst('{n: 3'd1, h: 4'd2, l: 4'd1, pat: "110", done_at: 4}, "after reset");
        tick();
        chk_outs("after reset idle", 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_burst_gen.md
PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, as the width of the phase-length fields.
REQ-002 The block SHALL have parameter N_W, default 3, as the width of the pulse-count field.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset: asynchronous, active-low.
REQ-005 start  input  1  burst request; sampled only when ready=1.
REQ-006 abort  input  1  synchronous burst cancel.
REQ-007 num_pulses  input  N_W  number of rising edges to generate, 0..2^N_W-1.
REQ-008 high_cyc  input  CNT_W  high-phase length in cycles; 0 treated as 1.
REQ-009 low_cyc  input  CNT_W  low-phase length in cycles; 0 treated as 1.
REQ-010 sig_out  output  1  generated waveform, driven directly from a flop.
REQ-011 ready  output  1  high when IDLE and able to accept start.
REQ-012 busy  output  1  high while a burst is in progress (HIGH or LOW state).
REQ-013 done  output  1  single-cycle pulse on normal burst completion.

Function
REQ-014 FSM states SHALL be IDLE, HIGH and LOW.
REQ-015 In IDLE, start=1 and abort=0 at cycle T SHALL latch num_pulses, high_cyc and low_cyc (H, L, N); later input changes have no effect on the burst.
REQ-016 If N>0 at acceptance, sig_out SHALL be 1 for H cycles starting at T+1, then 0 for L cycles; this HIGH/LOW pair repeats N times, so the rising-edge period is H+L.
REQ-017 After the final LOW phase the FSM SHALL enter IDLE at cycle T+1+N*(H+L); in that cycle done=1 and ready=1.
REQ-018 If N=0 at acceptance, the FSM SHALL stay in IDLE, sig_out stays 0, and done=1 at T+1.
REQ-019 start seen in the same cycle that done=1 SHALL be accepted, so back-to-back bursts have no idle gap.
REQ-020 start while busy=1 SHALL be ignored and not queued.
REQ-021 abort=1 in HIGH or LOW SHALL give sig_out=0, busy=0, ready=1 and state IDLE in the next cycle, and done SHALL NOT pulse.
REQ-022 abort and start together in IDLE: abort wins and start is ignored.
REQ-023 The phase counter SHALL load H-1 or L-1 on phase entry and decrement to 0; no wrap beyond 2^CNT_W-1 cycles per phase.
REQ-024 The pulse counter SHALL count remaining pulses, decrement when a LOW phase completes, and end the burst at 0.
REQ-025 ready and busy SHALL be mutually exclusive and decoded from state; done SHALL be registered.

Reset
REQ-026 On rst_n=0, the state SHALL become IDLE, all counters 0, sig_out=0, done=0, busy=0 and ready=1, asynchronously.
REQ-027 Reset asserted mid-burst SHALL drop sig_out to 0 immediately with no done pulse; after release the block is in IDLE with ready=1.

Structure
REQ-028 A shared package pulse_burst_pkg SHALL hold the state enum (IDLE, HIGH, LOW) and the CNT_W and N_W defaults.
REQ-029 The phase down-counter SHALL be a sub-module pulse_phase_timer (inputs load and load_val; output expired).
REQ-030 The total RTL SHALL be 120-400 lines across the package, pulse_phase_timer and pulse_burst_gen.

Verification
REQ-031 start at T with N=3, H=1, L=1 -> sig_out high at T+1, T+3 and T+5; done at T+7; the team's 3-edges-in-5-cycles checker flags once.
REQ-032 N=2, H=3, L=2 -> sig_out pattern 1110011100 from T+1; done at T+11; busy high from T+1 to T+10.
REQ-033 N=0 -> sig_out stays 0 and done at T+1; H=0, L=0 with N=2 -> behaves as H=1, L=1 (done at T+5).
REQ-034 abort at T+4 of an N=4, H=2, L=2 burst -> sig_out=0 and ready=1 at T+5, with no done for the burst.
REQ-035 Back-to-back: second start in the done cycle -> second burst's first high is the next cycle; start during busy -> no effect.
REQ-036 rst_n low mid-HIGH phase -> sig_out=0 asynchronously, no done; a start after release behaves per REQ-016.
